// File: rtl/mem_pkg.sv
// Shared types and default DRAM timing for the main-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    CLOSED    = 2'd0,
    PRECHARGE = 2'd1,
    ACTIVATE  = 2'd2,
    OPEN      = 2'd3
  } state_t;

  localparam int unsigned T_RP_DEF  = 2;
  localparam int unsigned T_RCD_DEF = 3;

endpackage

// File: rtl/ram_storage.sv
// Single-port synchronous word array with registered, write-first read port.
module ram_storage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Backing storage survives reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Single-bank DRAM responder with an open-row buffer; row misses stall via ram_ready.
// Optional row-hit/miss statistics are enabled by defining RAM_STATS_EN.
module ram_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH_LOG2     = 12,
  parameter int unsigned ROW_WORDS_LOG2 = 4,
  parameter int unsigned T_RP           = T_RP_DEF,
  parameter int unsigned T_RCD          = T_RCD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_read_en,
  input  logic                  ram_write_en,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_ready,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_rvalid
`ifdef RAM_STATS_EN
  ,
  output logic [15:0]           row_hits,
  output logic [15:0]           row_misses
`endif
);

  localparam int unsigned ROW_W = ADDR_WIDTH - ROW_WORDS_LOG2;
  localparam int unsigned T_MAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ROW_W-1:0]  open_row, open_row_nxt;
  logic              row_valid, row_valid_nxt;
  logic [ROW_W-1:0]  row;
  logic              req;
  logic              accept;
  logic              rd_accept;
  logic              wr_accept;

  assign row       = ram_addr[ADDR_WIDTH-1:ROW_WORDS_LOG2];
  assign req       = ram_read_en | ram_write_en;
  assign accept    = req & ram_ready;
  assign wr_accept = accept & ram_write_en;
  assign rd_accept = accept & ram_read_en & ~ram_write_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLOSED;
      cnt        <= '0;
      open_row   <= '0;
      row_valid  <= 1'b0;
      ram_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      open_row   <= open_row_nxt;
      row_valid  <= row_valid_nxt;
      ram_rvalid <= rd_accept;
    end
  end

  // Timed states keep counting even if the request is withdrawn.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    open_row_nxt  = open_row;
    row_valid_nxt = row_valid;
    ram_ready     = 1'b0;
    case (state)
      CLOSED: begin
        if (req) begin
          state_nxt = ACTIVATE;
          cnt_nxt   = CNT_W'(T_RCD - 1);
        end
      end
      PRECHARGE: begin
        if (cnt == '0) begin
          state_nxt = ACTIVATE;
          cnt_nxt   = CNT_W'(T_RCD - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ACTIVATE: begin
        if (cnt == '0) begin
          state_nxt     = OPEN;
          open_row_nxt  = row;
          row_valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      OPEN: begin
        ram_ready = row_valid && (row == open_row);
        if (req && (row != open_row)) begin
          state_nxt     = PRECHARGE;
          cnt_nxt       = CNT_W'(T_RP - 1);
          row_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = CLOSED;
    endcase
  end

  ram_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (wr_accept),
    .re    (rd_accept),
    .addr  (ram_addr[DEPTH_LOG2-1:0]),
    .wdata (ram_data_in),
    .rdata (ram_data)
  );

`ifdef RAM_STATS_EN
  logic enter_act;
  logic act_done;
  logic first_pending;

  assign enter_act = (state_nxt == ACTIVATE) && (state != ACTIVATE);
  assign act_done  = (state == ACTIVATE) && (state_nxt == OPEN);

  // The first accept after an activation is the miss itself, not a hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_pending <= 1'b0;
      row_hits      <= '0;
      row_misses    <= '0;
    end else begin
      if (act_done)     first_pending <= 1'b1;
      else if (accept)  first_pending <= 1'b0;
      if (accept && !first_pending && row_hits != 16'hFFFF)
        row_hits <= row_hits + 16'd1;
      if (enter_act && row_misses != 16'hFFFF)
        row_misses <= row_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed and random bench for ram_responder against a latency/row-buffer reference model.
module tb_ram_responder;

  localparam int unsigned T_RP  = 2;
  localparam int unsigned T_RCD = 3;

  logic        clk;
  logic        reset;
  logic [29:0] ram_addr;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [31:0] ram_data_in;
  logic        ram_ready;
  logic [31:0] ram_data;
  logic        ram_rvalid;
`ifdef RAM_STATS_EN
  logic [15:0] row_hits;
  logic [15:0] row_misses;
`endif

  ram_responder dut (
    .clk          (clk),
    .reset        (reset),
    .ram_addr     (ram_addr),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_data_in  (ram_data_in),
    .ram_ready    (ram_ready),
    .ram_data     (ram_data),
    .ram_rvalid   (ram_rvalid)
`ifdef RAM_STATS_EN
    ,
    .row_hits     (row_hits),
    .row_misses   (row_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: storage contents, open-row tracking, statistics.
  logic [31:0] m_mem   [4096];
  bit          m_known [4096];
  bit          m_open  = 0;
  logic [25:0] m_row   = '0;
  bit          m_first = 0;
  int          m_hits  = 0;
  int          m_miss  = 0;

  bit          exp_rv   = 0;
  logic [31:0] exp_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check last cycle's read response.
  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("rvalid", 32'(ram_rvalid), 32'(exp_rv));
    if (exp_rv) chk("rdata", ram_data, exp_data);
    exp_rv = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      ram_read_en  = 1'b0;
      ram_write_en = 1'b0;
    end
  endtask

  // Present one request, wait for accept, check latency against the row model.
  task automatic issue(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] data);
    int lat;
    int n;
    logic [25:0] r;
    logic [11:0] idx;
    tick();
    ram_read_en  = rd;
    ram_write_en = wr;
    ram_addr     = addr;
    ram_data_in  = data;
    r   = addr[29:4];
    idx = addr[11:0];
    if (!m_open)         begin lat = T_RCD + 1;        m_miss++; m_first = 1; end
    else if (m_row != r) begin lat = T_RP + T_RCD + 1; m_miss++; m_first = 1; end
    else                       lat = 0;
    m_open = 1;
    m_row  = r;
    #1;
    n = 0;
    while (!ram_ready && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk("accept_latency", 32'(n), 32'(lat));
    if (m_first) m_first = 0;
    else if (m_hits < 65535) m_hits++;
    if (wr) begin
      m_mem[idx]   = data;
      m_known[idx] = 1;
    end else if (rd) begin
      exp_rv   = 1;
      exp_data = m_mem[idx];
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"},  32'(ram_ready),  32'd0);
    chk({tag, "_rvalid"}, 32'(ram_rvalid), 32'd0);
    chk({tag, "_data"},   ram_data,        32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef RAM_STATS_EN
    chk({tag, "_hits"},   32'(row_hits),   32'(m_hits));
    chk({tag, "_misses"}, 32'(row_misses), 32'(m_miss));
`else
    chk({tag, "_nostats_ready_idle"}, 32'(ram_rvalid), 32'(exp_rv));
`endif
  endtask

  task automatic reset_model();
    m_open = 0;
    m_first = 0;
    m_hits = 0;
    m_miss = 0;
    exp_rv = 0;
  endtask

  initial begin
    logic [31:0] pre;
    logic [29:0] a;
    logic        rd;
    logic        wr;
    reset        = 1'b1;
    ram_addr     = '0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    ram_data_in  = '0;
    for (int i = 0; i < 4096; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 0;
    end

    idle(2);
    #1;
    check_idle_outputs("in_reset");
    reset = 1'b0;
    idle(1);
    check_idle_outputs("post_reset");
    check_stats("post_reset");

    // Seed 0x40, reset, then a cold read must still see it.
    pre = $urandom;
    issue(1'b0, 1'b1, 30'h40, pre);
    idle(2);
    reset = 1'b1;
    #1;
    check_idle_outputs("second_reset");
    idle(1);
    reset = 1'b0;
    reset_model();
    issue(1'b1, 1'b0, 30'h40, '0);
    idle(3);

    // Write burst then read burst in one row.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    reset_model();
    for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 30'(32'h100 + i), 32'h100 + i);
    for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 30'(32'h100 + i), '0);
    idle(2);
    check_stats("burst");

    // Row conflict.
    issue(1'b0, 1'b1, 30'h10, 32'h1111_0010);
    issue(1'b0, 1'b1, 30'h20, 32'h2222_0020);
    idle(1);
    issue(1'b1, 1'b0, 30'h10, '0);
    issue(1'b1, 1'b0, 30'h20, '0);
    idle(2);
    check_stats("conflict");

    // Simultaneous read and write: write wins.
    issue(1'b1, 1'b1, 30'h5, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 30'h5, '0);
    idle(2);

    // Address aliasing above DEPTH.
    issue(1'b0, 1'b1, 30'h1000, 32'h0000_00A5);
    issue(1'b1, 1'b0, 30'h0, '0);
    idle(2);

    // Reset during activation abandons the request.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    reset_model();
    tick();
    ram_read_en = 1'b1;
    ram_addr    = 30'h40;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_in_activate");
    tick();
    reset       = 1'b0;
    ram_read_en = 1'b0;
    reset_model();
    issue(1'b1, 1'b0, 30'h40, '0);
    idle(2);
    check_stats("after_abort");

    // Random traffic over a few rows, with aliases and gaps.
    for (int k = 0; k < 80; k++) begin
      a = 30'(32'h300 + $urandom_range(0, 47));
      if ($urandom_range(0, 7) == 0) a = a + 30'h1000;
      wr = !m_known[a[11:0]] || ($urandom_range(0, 1) == 0);
      rd = !wr || ($urandom_range(0, 7) == 0);
      issue(rd, wr, a, $urandom);
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    check_stats("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
